// File: rtl/game_pkg.sv
// Shared constants, state encoding and digit helper for the guessing-game scorer.
package game_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int HIST_DEPTH = 6;
    localparam int CNT_W      = 3;
    localparam int IDX_W      = 3;

    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_COMMIT
    } score_state_t;

    // Values 0-9 are real digits; anything above (including the blank) never matches.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/score_history.sv
// Per-turn result store: one {A,B} entry per turn slot, valid bits, entry count
// and a combinational read port that returns zero for unwritten slots.
module score_history
    import game_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_a,
    input  logic [CNT_W-1:0] wr_b,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_a,
    output logic [CNT_W-1:0] rd_b,
    output logic             rd_valid,
    output logic [IDX_W-1:0] count
);

    logic [CNT_W-1:0]      r_a [0:HIST_DEPTH-1];
    logic [CNT_W-1:0]      r_b [0:HIST_DEPTH-1];
    logic [HIST_DEPTH-1:0] r_valid;
    logic [IDX_W-1:0]      r_count;
    logic [HIST_DEPTH-1:0] w_hit;
    logic                  w_new_entry;

    // One-hot decode of the write slot; out-of-range indices hit nothing.
    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // A write only grows the count when it lands on a previously empty slot.
    assign w_new_entry = |(w_hit & ~r_valid);

    // Entry storage and valid bits; clr wipes everything like reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (clr) begin
            r_valid <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                if (w_hit[k]) begin
                    r_a[k]     <= wr_a;
                    r_b[k]     <= wr_b;
                    r_valid[k] <= 1'b1;
                end
            end
        end
    end

    // Number of distinct slots written since the last clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_new_entry) begin
            r_count <= r_count + IDX_W'(1);
        end
    end

    // Asynchronous read; invalid or out-of-range slots read as zero.
    always_comb begin
        rd_a     = '0;
        rd_b     = '0;
        rd_valid = 1'b0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            if (rd_idx == IDX_W'(k) && r_valid[k]) begin
                rd_a     = r_a[k];
                rd_b     = r_b[k];
                rd_valid = 1'b1;
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/score_sequencer.sv
// Multi-cycle Bulls/Cows scorer: walks all 16 secret/guess digit pairs one per
// cycle, then commits A/B/win/err and logs the turn into the history store.
module score_sequencer
    import game_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               start,
    input  logic [DIGIT_W-1:0] secret [0:NUM_DIGITS-1],
    input  logic [DIGIT_W-1:0] guess  [0:NUM_DIGITS-1],
    input  logic [IDX_W-1:0]   turn_idx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count_a,
    output logic [CNT_W-1:0]   count_b,
    output logic               win,
    output logic               err,
    input  logic [IDX_W-1:0]   hist_rd_idx,
    output logic [CNT_W-1:0]   hist_rd_a,
    output logic [CNT_W-1:0]   hist_rd_b,
    output logic               hist_rd_valid,
    output logic [IDX_W-1:0]   hist_count
);

    score_state_t       r_state;
    score_state_t       w_next_state;
    logic               w_capture;
    logic               w_step;
    logic               w_commit;

    logic [DIGIT_W-1:0] r_secret [0:NUM_DIGITS-1];
    logic [DIGIT_W-1:0] r_guess  [0:NUM_DIGITS-1];
    logic [IDX_W-1:0]   r_turn;
    logic [1:0]         r_i;
    logic [1:0]         r_j;
    logic [CNT_W-1:0]   r_acc_a;
    logic [CNT_W-1:0]   r_acc_b;
    logic               r_err_acc;
    logic [CNT_W-1:0]   r_count_a;
    logic [CNT_W-1:0]   r_count_b;
    logic               r_win;
    logic               r_err;
    logic               r_done;

    logic [DIGIT_W-1:0] w_sec_d;
    logic [DIGIT_W-1:0] w_gss_d;
    logic               w_bad;
    logic               w_match;
    logic               w_hist_we;

    // State register; clr aborts any operation back to IDLE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-state datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_step = 1'b1;
                if (r_i == 2'd3 && r_j == 2'd3) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_sec_d = r_secret[r_i];
    assign w_gss_d = r_guess[r_j];
    assign w_bad   = !is_digit(w_sec_d) || !is_digit(w_gss_d);
    assign w_match = !w_bad && (w_sec_d == w_gss_d);

    // Operand capture, pairwise accumulation and result commit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_secret[k] <= '0;
                r_guess[k]  <= '0;
            end
            r_turn    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_err_acc <= 1'b0;
            r_count_a <= '0;
            r_count_b <= '0;
            r_win     <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else if (clr) begin
            r_i       <= '0;
            r_j       <= '0;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_err_acc <= 1'b0;
            r_count_a <= '0;
            r_count_b <= '0;
            r_win     <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_capture) begin
                r_secret  <= secret;
                r_guess   <= guess;
                r_turn    <= turn_idx;
                r_i       <= '0;
                r_j       <= '0;
                r_acc_a   <= '0;
                r_acc_b   <= '0;
                r_err_acc <= 1'b0;
            end
            if (w_step) begin
                // Duplicated digits can push the counts past NUM_DIGITS; saturate rather than wrap.
                if (w_match) begin
                    if (r_i == r_j) begin
                        if (r_acc_a != '1) r_acc_a <= r_acc_a + CNT_W'(1);
                    end else begin
                        if (r_acc_b != '1) r_acc_b <= r_acc_b + CNT_W'(1);
                    end
                end
                if (w_bad) begin
                    r_err_acc <= 1'b1;
                end
                r_j <= r_j + 2'd1;
                if (r_j == 2'd3) begin
                    r_i <= r_i + 2'd1;
                end
            end
            if (w_commit) begin
                r_count_a <= r_acc_a;
                r_count_b <= r_acc_b;
                r_win     <= (r_acc_a == CNT_W'(NUM_DIGITS));
                r_err     <= r_err_acc;
            end
        end
    end

    assign w_hist_we = w_commit && (r_turn < IDX_W'(HIST_DEPTH));

    score_history u_history (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr      (clr),
        .wr_en    (w_hist_we),
        .wr_idx   (r_turn),
        .wr_a     (r_acc_a),
        .wr_b     (r_acc_b),
        .rd_idx   (hist_rd_idx),
        .rd_a     (hist_rd_a),
        .rd_b     (hist_rd_b),
        .rd_valid (hist_rd_valid),
        .count    (hist_count)
    );

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign count_a = r_count_a;
    assign count_b = r_count_b;
    assign win     = r_win;
    assign err     = r_err;

endmodule
